// File: rtl/cordic_pkg.sv
// cordic_pkg: shared CORDIC state type, arctangent table and gain.
package cordic_pkg;
  typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_t;
  // atan(2^-i) on a binary-angle scale where 2^31 = pi
  localparam logic [31:0] ATAN_TABLE [24] = '{
    32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
    32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
    32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
    32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
    32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
    32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051
  };
  // CORDIC gain K as unsigned Q2.30
  localparam logic [31:0] CORDIC_K = 32'd1768195363;
endpackage

// File: rtl/atan_lut.sv
// atan_lut: per-iteration arctangent rounded onto the (WIDTH+1)-bit angle scale.
module atan_lut import cordic_pkg::*; #(
  parameter int WIDTH = 16
) (
  input  logic [4:0]         idx,
  output logic signed [WIDTH:0] atan
);
  assign atan = (WIDTH+1)'((ATAN_TABLE[idx] + (32'd1 << (31 - WIDTH))) >> (32 - WIDTH));
endmodule

// File: rtl/atan2_cordic.sv
// atan2_cordic: iterative vectoring-mode CORDIC giving atan2(y,x) and K-scaled magnitude.
module atan2_cordic import cordic_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int ITER  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] angle_out,
  output logic [WIDTH+1:0]        mag_out,
  output logic                    zero_flag
);
  localparam int CW = $clog2(ITER);
  localparam logic signed [WIDTH:0] PI = (WIDTH+1)'(1) << (WIDTH-1);
  state_t state;
  logic [CW-1:0] cnt;
  logic signed [WIDTH+1:0] x, y, x_nx, y_nx, x_ext, y_ext;
  logic signed [WIDTH:0] z, z_nx, atan;
  logic zf, d;
  atan_lut #(.WIDTH(WIDTH)) u_lut (.idx(5'(cnt)), .atan(atan));
  always_comb begin
    x_ext = {{2{x_in[WIDTH-1]}}, x_in};
    y_ext = {{2{y_in[WIDTH-1]}}, y_in};
    d = y[WIDTH+1];
    x_nx = d ? x - (y >>> cnt) : x + (y >>> cnt);
    y_nx = d ? y + (x >>> cnt) : y - (x >>> cnt);
    z_nx = d ? z - atan : z + atan;
  end
  // left-half-plane inputs are mirrored through the origin and start from +/-pi
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      x <= '0;
      y <= '0;
      z <= '0;
      zf <= 1'b0;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      angle_out <= '0;
      mag_out <= '0;
      zero_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          x <= x_in[WIDTH-1] ? -x_ext : x_ext;
          y <= x_in[WIDTH-1] ? -y_ext : y_ext;
          z <= x_in[WIDTH-1] ? (y_in[WIDTH-1] ? -PI : PI) : '0;
          zf <= (x_in == '0) && (y_in == '0);
          cnt <= '0;
          in_ready <= 1'b0;
          state <= ROTATE;
        end
        ROTATE: begin
          x <= x_nx;
          y <= y_nx;
          z <= z_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(ITER-1)) begin
            angle_out <= zf ? '0 : z_nx[WIDTH-1:0];
            mag_out <= zf ? '0 : x_nx;
            zero_flag <= zf;
            out_valid <= 1'b1;
            state <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
